// File: rtl/uart_lite_pkg.sv
// Shared register map for the UART-lite responder and the I/O controller that polls it.
package uart_lite_pkg;

  // Byte offsets of the four registers; only bits [3:2] take part in decode.
  localparam logic [31:0] RX_FIFO_OFS = 32'h0;
  localparam logic [31:0] TX_FIFO_OFS = 32'h4;
  localparam logic [31:0] STAT_OFS    = 32'h8;
  localparam logic [31:0] CTRL_OFS    = 32'hC;

  // STAT bit positions.
  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_RX_FULL  = 1;
  localparam int unsigned STAT_TX_EMPTY = 2;
  localparam int unsigned STAT_TX_FULL  = 3;

  // CTRL bit positions.
  localparam int unsigned CTRL_CLR_TX = 0;
  localparam int unsigned CTRL_CLR_RX = 1;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register selected by address bits [3:2].
  typedef enum logic [1:0] {
    REG_RX   = RX_FIFO_OFS[3:2],
    REG_TX   = TX_FIFO_OFS[3:2],
    REG_STAT = STAT_OFS[3:2],
    REG_CTRL = CTRL_OFS[3:2]
  } reg_sel_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  // Map the decoded address bits onto a register select; upper bits alias.
  function automatic reg_sel_e decode_reg(input logic [1:0] addr_bits);
    return reg_sel_e'(addr_bits);
  endfunction

endpackage

// File: rtl/uart_lite_axi_responder_byte_fifo.sv
// Byte-wide synchronous FIFO with clear; supports push+pop in the same cycle, even when full.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       clear,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; clear overrides any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_lite_axi_responder.sv
// AXI4-lite slave emulating the UART register map, backed by host-side RX/TX byte FIFOs.
module uart_lite_axi_responder
  import uart_lite_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  input  logic        rx_in_valid,
  output logic        rx_in_ready,
  input  logic [7:0]  rx_in_data,
  output logic        tx_out_valid,
  input  logic        tx_out_ready,
  output logic [7:0]  tx_out_data
);

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;

  logic [1:0]  aw_bits_q;
  logic [7:0]  wdata_q;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_hs, w_hs, ar_hs, wr_commit;
  reg_sel_e    wr_sel, rd_sel;
  logic [7:0]  wr_byte;
  logic [31:0] stat_word;

  logic        rx_push, rx_pop, rx_clear, rx_empty, rx_full;
  logic        tx_push, tx_clear, tx_empty, tx_full;
  logic [7:0]  rx_head;

  logic        unused_ok;
  assign unused_ok = ^{axi_awaddr[31:4], axi_awaddr[1:0], axi_araddr[31:4],
                       axi_araddr[1:0], axi_wdata[31:8], axi_wstrb};

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  // A half already held comes from its register; the half arriving now comes from the bus.
  assign wr_sel  = decode_reg((wr_state_q == W_HAVE_ADDR) ? aw_bits_q : axi_awaddr[3:2]);
  assign wr_byte = (wr_state_q == W_HAVE_DATA) ? wdata_q : axi_wdata[7:0];
  assign rd_sel  = decode_reg(axi_araddr[3:2]);

  // ---------------- write channel FSM ----------------

  // Write state register.
  always_ff @(posedge clk) begin
    if (!rstn) wr_state_q <= W_IDLE;
    else       wr_state_q <= wr_state_d;
  end

  // Write next state; the commit fires on the cycle the second half arrives.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          wr_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wr_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from state.
  always_comb begin
    axi_awready = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_DATA);
    axi_wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_ADDR);
    axi_bvalid  = (wr_state_q == W_RESP);
  end

  // Response code latched at commit: only TX and CTRL are writable.
  always_comb begin
    bresp_d = bresp_q;
    if (wr_commit)
      bresp_d = ((wr_sel == REG_TX) || (wr_sel == REG_CTRL)) ? RESP_OKAY : RESP_SLVERR;
  end

  // Holding registers for the address/data half that arrives first, plus bresp.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_bits_q <= '0;
      wdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_bits_q <= axi_awaddr[3:2];
      if (w_hs)  wdata_q   <= axi_wdata[7:0];
      bresp_q <= bresp_d;
    end
  end

  assign axi_bresp = bresp_q;

  assign tx_push  = wr_commit && (wr_sel == REG_TX);
  assign tx_clear = wr_commit && (wr_sel == REG_CTRL) && wr_byte[CTRL_CLR_TX];
  assign rx_clear = wr_commit && (wr_sel == REG_CTRL) && wr_byte[CTRL_CLR_RX];

  // ---------------- read channel FSM ----------------

  // Read state register.
  always_ff @(posedge clk) begin
    if (!rstn) rd_state_q <= R_IDLE;
    else       rd_state_q <= rd_state_d;
  end

  // Read next state: one accept, then hold the response until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
      R_RESP:  if (axi_rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel handshake outputs decoded from state.
  always_comb begin
    axi_arready = (rd_state_q == R_IDLE);
    axi_rvalid  = (rd_state_q == R_RESP);
  end

  // STAT snapshot of the FIFO flags.
  always_comb begin
    stat_word                = '0;
    stat_word[STAT_RX_VALID] = !rx_empty;
    stat_word[STAT_RX_FULL]  = rx_full;
    stat_word[STAT_TX_EMPTY] = tx_empty;
    stat_word[STAT_TX_FULL]  = tx_full;
  end

  // Read data and response chosen at accept; held registers keep them stable.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      unique case (rd_sel)
        REG_RX: begin
          rdata_d = rx_empty ? '0 : {24'h0, rx_head};
          rresp_d = RESP_OKAY;
        end
        REG_STAT: begin
          rdata_d = stat_word;
          rresp_d = RESP_OKAY;
        end
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  // Read response registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign axi_rdata = rdata_q;
  assign axi_rresp = rresp_q;

  assign rx_pop = ar_hs && (rd_sel == REG_RX);

  // ---------------- FIFOs ----------------

  assign rx_in_ready  = !rx_full;
  assign rx_push      = rx_in_valid && rx_in_ready;
  assign tx_out_valid = !tx_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rx_push),
    .push_data (rx_in_data),
    .pop       (rx_pop),
    .clear     (rx_clear),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (tx_push),
    .push_data (wr_byte),
    .pop       (tx_out_ready),
    .clear     (tx_clear),
    .head      (tx_out_data),
    .empty     (tx_empty),
    .full      (tx_full)
  );

endmodule

// File: tb/tb_uart_lite_axi_responder.sv
// Directed self-checking bench for uart_lite_axi_responder.
module tb_uart_lite_axi_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        axi_awvalid = 1'b0, axi_awready;
  logic [31:0] axi_awaddr = '0;
  logic        axi_wvalid = 1'b0, axi_wready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = 4'hF;
  logic        axi_bvalid, axi_bready = 1'b0;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid = 1'b0, axi_arready;
  logic [31:0] axi_araddr = '0;
  logic        axi_rvalid, axi_rready = 1'b0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        rx_in_valid = 1'b0, rx_in_ready;
  logic [7:0]  rx_in_data = '0;
  logic        tx_out_valid, tx_out_ready = 1'b0;
  logic [7:0]  tx_out_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  uart_lite_axi_responder #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_awaddr   (axi_awaddr),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_bvalid   (axi_bvalid),
    .axi_bready   (axi_bready),
    .axi_bresp    (axi_bresp),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_araddr   (axi_araddr),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .rx_in_valid  (rx_in_valid),
    .rx_in_ready  (rx_in_ready),
    .rx_in_data   (rx_in_data),
    .tx_out_valid (tx_out_valid),
    .tx_out_ready (tx_out_ready),
    .tx_out_data  (tx_out_data)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int unsigned n = 0;
    logic aw_hs, w_hs;
    axi_awaddr  = a;
    axi_wdata   = d;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    axi_bready  = 1'b1;
    while ((axi_awvalid || axi_wvalid) && n < 20) begin
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      tick();
      n++;
      if (aw_hs) axi_awvalid = 1'b0;
      if (w_hs)  axi_wvalid  = 1'b0;
    end
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    expect_eq("wr_bvalid_next_cycle", 32'(axi_bvalid), 32'd1);
    while (!axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    resp = axi_bresp;
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int unsigned n = 0;
    logic hs;
    axi_araddr  = a;
    axi_arvalid = 1'b1;
    axi_rready  = 1'b1;
    while (axi_arvalid && n < 20) begin
      hs = axi_arready;
      tick();
      n++;
      if (hs) axi_arvalid = 1'b0;
    end
    axi_arvalid = 1'b0;
    expect_eq("rd_latency1", 32'(axi_rvalid), 32'd1);
    while (!axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    d    = axi_rdata;
    resp = axi_rresp;
    tick();
    axi_rready = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    int unsigned n = 0;
    rx_in_valid = 1'b1;
    rx_in_data  = b;
    while (!rx_in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    rx_in_valid = 1'b0;
  endtask

  task automatic read_stat(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    expect_eq(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    // Reset state
    repeat (3) tick();
    expect_eq("rst_awready", 32'(axi_awready), 32'd1);
    expect_eq("rst_wready",  32'(axi_wready),  32'd1);
    expect_eq("rst_arready", 32'(axi_arready), 32'd1);
    expect_eq("rst_bvalid",  32'(axi_bvalid),  32'd0);
    expect_eq("rst_rvalid",  32'(axi_rvalid),  32'd0);
    expect_eq("rst_bresp",   32'(axi_bresp),   32'd0);
    expect_eq("rst_rresp",   32'(axi_rresp),   32'd0);
    expect_eq("rst_rdata",   axi_rdata,        32'd0);
    expect_eq("rst_rx_in_ready",  32'(rx_in_ready),  32'd1);
    expect_eq("rst_tx_out_valid", 32'(tx_out_valid), 32'd0);
    rstn = 1'b1;
    tick();

    // Single RX byte through STAT and RX FIFO
    rx_push(8'h41);
    read_stat("stat_rx1", 32'h8, 32'h5);
    axi_read(32'h0, d, r);
    expect_eq("rx_read_41", d, 32'h41);
    expect_eq("rx_read_resp", 32'(r), 32'd0);
    expect_eq("arready_back", 32'(axi_arready), 32'd1);
    read_stat("stat_rx_drained", 32'h8, 32'h4);

    // Write to TX with W one cycle ahead of AW
    axi_bready = 1'b0;
    axi_wdata  = 32'h123;
    axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    expect_eq("wfirst_wready_low", 32'(axi_wready), 32'd0);
    expect_eq("wfirst_awready_high", 32'(axi_awready), 32'd1);
    expect_eq("wfirst_no_bvalid", 32'(axi_bvalid), 32'd0);
    axi_awaddr  = 32'h4;
    axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    expect_eq("wfirst_bvalid", 32'(axi_bvalid), 32'd1);
    expect_eq("wfirst_bresp", 32'(axi_bresp), 32'd0);
    expect_eq("wfirst_awready_low", 32'(axi_awready), 32'd0);
    expect_eq("wfirst_tx_valid", 32'(tx_out_valid), 32'd1);
    expect_eq("wfirst_tx_data", 32'(tx_out_data), 32'h23);
    tick();
    expect_eq("bvalid_holds", 32'(axi_bvalid), 32'd1);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    expect_eq("after_b_bvalid", 32'(axi_bvalid), 32'd0);
    expect_eq("after_b_awready", 32'(axi_awready), 32'd1);
    expect_eq("after_b_wready", 32'(axi_wready), 32'd1);
    tx_out_ready = 1'b1;
    tick();
    tx_out_ready = 1'b0;
    expect_eq("tx_popped", 32'(tx_out_valid), 32'd0);

    // Fill RX, then refill behind each read
    for (int i = 0; i < 16; i++) rx_push(8'(8'h10 + i));
    expect_eq("rx_full_ready", 32'(rx_in_ready), 32'd0);
    read_stat("stat_rx_full", 32'h8, 32'h7);
    for (int k = 0; k < 4; k++) begin
      rx_in_valid = 1'b1;
      rx_in_data  = 8'(8'h80 + k);
      axi_read(32'h0, d, r);
      expect_eq("rx_full_pop", d, 32'(8'h10 + k));
      expect_eq("rx_refilled", 32'(rx_in_ready), 32'd0);
    end
    rx_in_valid = 1'b0;
    read_stat("stat_rx_still_full", 32'h8, 32'h7);
    for (int j = 0; j < 16; j++) begin
      axi_read(32'h0, d, r);
      expect_eq("rx_order", d, (j < 12) ? 32'(8'h14 + j) : 32'(8'h80 + j - 12));
    end
    read_stat("stat_rx_empty", 32'h8, 32'h4);

    // Overfill TX: 17th byte dropped, still OKAY
    for (int i = 0; i < 17; i++) begin
      axi_write(32'h4, 32'(8'h60 + i), r);
      expect_eq("tx_fill_bresp", 32'(r), 32'd0);
    end
    read_stat("stat_tx_full", 32'h8, 32'h8);
    for (int j = 0; j < 16; j++) begin
      expect_eq("tx_drain_valid", 32'(tx_out_valid), 32'd1);
      expect_eq("tx_drain_data", 32'(tx_out_data), 32'(8'h60 + j));
      tx_out_ready = 1'b1;
      tick();
      tx_out_ready = 1'b0;
    end
    expect_eq("tx_drained", 32'(tx_out_valid), 32'd0);

    // Error responses and CTRL clears
    axi_read(32'h4, d, r);
    expect_eq("rd_tx_rdata", d, 32'd0);
    expect_eq("rd_tx_rresp", 32'(r), 32'd2);
    axi_read(32'hC, d, r);
    expect_eq("rd_ctrl_rresp", 32'(r), 32'd2);
    axi_write(32'h8, 32'hFF, r);
    expect_eq("wr_stat_bresp", 32'(r), 32'd2);
    axi_write(32'h0, 32'h77, r);
    expect_eq("wr_rx_bresp", 32'(r), 32'd2);
    read_stat("stat_after_bad_wr", 32'h8, 32'h4);
    axi_write(32'h4, 32'hA5, r);
    rx_push(8'h11);
    rx_push(8'h22);
    read_stat("stat_alias_18", 32'h18, 32'h1);
    axi_write(32'h1C, 32'h1, r);
    expect_eq("ctrl_bresp", 32'(r), 32'd0);
    read_stat("stat_clr_tx", 32'h8, 32'h5);
    axi_write(32'h4, 32'h5A, r);
    axi_write(32'hC, 32'h3, r);
    read_stat("stat_clr_both", 32'h8, 32'h4);
    axi_read(32'h0, d, r);
    expect_eq("rd_empty_rx", d, 32'd0);
    expect_eq("rd_empty_rresp", 32'(r), 32'd0);

    // Reset while a write response is pending
    rx_push(8'h31);
    rx_push(8'h32);
    rx_push(8'h33);
    axi_bready  = 1'b0;
    axi_awaddr  = 32'h4;
    axi_wdata   = 32'h99;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    expect_eq("pre_rst_bvalid", 32'(axi_bvalid), 32'd1);
    rstn = 1'b0;
    tick();
    expect_eq("mid_rst_bvalid", 32'(axi_bvalid), 32'd0);
    expect_eq("mid_rst_awready", 32'(axi_awready), 32'd1);
    expect_eq("mid_rst_wready", 32'(axi_wready), 32'd1);
    expect_eq("mid_rst_arready", 32'(axi_arready), 32'd1);
    expect_eq("mid_rst_rx_ready", 32'(rx_in_ready), 32'd1);
    expect_eq("mid_rst_tx_valid", 32'(tx_out_valid), 32'd0);
    rstn = 1'b1;
    tick();
    expect_eq("post_rst_bvalid", 32'(axi_bvalid), 32'd0);
    read_stat("stat_post_rst", 32'h8, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
